// File: rtl/sub_pipe_pkg.sv
// Shared helpers for the pipelined signed subtractor: wide subtract with
// overflow flag and signed-extreme constants, all sized by a run-time width.
package sub_pipe_pkg;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned IDX_W = $clog2(MAX_W);

  // Returns {overflow, raw} where raw is a - b truncated to w bits (upper bits zero).
  function automatic logic [MAX_W:0] signed_sub_ovf(input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b,
                                                    input int unsigned      w);
    logic [MAX_W-1:0] raw;
    logic [IDX_W-1:0] msb;
    logic             ovf;
    raw = a + ~b + MAX_W'(1);
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i >= w) raw[IDX_W'(i)] = 1'b0;
    end
    msb = IDX_W'(w - 1);
    ovf = (a[msb] != b[msb]) && (raw[msb] != a[msb]);
    return {ovf, raw};
  endfunction

  function automatic logic [MAX_W-1:0] smax(input int unsigned w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] smin(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/signed_sub_with_overflow_pipe_stage_reg.sv
// One valid/ready pipeline slot: loads when upstream is valid and the slot is
// free or draining this cycle; otherwise holds its contents.
module pipe_stage_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_vld,
  output logic          up_rdy_c,
  input  logic [DW-1:0] d,
  output logic          dn_vld,
  input  logic          dn_rdy,
  output logic [DW-1:0] q
);

  logic load;

  assign up_rdy_c = !dn_vld || dn_rdy;
  assign load     = up_vld && up_rdy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_vld <= 1'b0;
      q      <= '0;
    end else if (load) begin
      dn_vld <= 1'b1;
      q      <= d;
    end else if (dn_rdy) begin
      dn_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/signed_sub_with_overflow_pipe.sv
// Two-stage streaming a - b with signed-overflow detect, optional clamping,
// and a saturating count of overflowing results handed downstream.
module signed_sub_with_overflow_pipe #(
  parameter int unsigned W        = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [W-1:0]     diff,
  output logic             overflow,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);
  import sub_pipe_pkg::*;

  localparam int unsigned S1_W    = 2 * W;
  localparam int unsigned S2_W    = W + 1;
  localparam logic [W-1:0] SAT_MAX = W'(smax(W));
  localparam logic [W-1:0] SAT_MIN = W'(smin(W));

  logic              s1_vld;
  logic              s2_rdy;
  logic [S1_W-1:0]   s1_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [MAX_W:0]    sub_res;
  logic [MAX_W-W-1:0] sub_unused;
  logic              ovf_c;
  logic [W-1:0]      diff_c;
  logic [S2_W-1:0]   s2_q;

  pipe_stage_reg #(.DW(S1_W)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_vld   (up_vld),
    .up_rdy_c (up_rdy),
    .d        ({a, b}),
    .dn_vld   (s1_vld),
    .dn_rdy   (s2_rdy),
    .q        (s1_q)
  );

  assign {a_q, b_q} = s1_q;
  assign sub_res    = signed_sub_ovf(MAX_W'(a_q), MAX_W'(b_q), W);
  assign sub_unused = sub_res[MAX_W-1:W];
  assign ovf_c      = sub_res[MAX_W];

  // Clamp toward the minuend's sign: overflow only happens when signs differ.
  always_comb begin
    diff_c = sub_res[W-1:0];
    if (SATURATE && ovf_c) diff_c = a_q[W-1] ? SAT_MIN : SAT_MAX;
  end

  pipe_stage_reg #(.DW(S2_W)) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_vld   (s1_vld),
    .up_rdy_c (s2_rdy),
    .d        ({ovf_c, diff_c}),
    .dn_vld   (down_vld),
    .dn_rdy   (down_rdy),
    .q        (s2_q)
  );

  assign {overflow, diff} = s2_q;

  // Clear wins over a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (down_vld && down_rdy && overflow && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule
